// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state type and field widths for the I2C request arbiter
package i2c_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} arb_state_t;
  localparam int I2C_ADDR_W = 8;
  localparam int I2C_DATA_W = 8;
  localparam int DEF_TIMEOUT = 1023;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first valid index at or above ptr with wrap
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (valid[j]) idx = j;
    end
    any = |valid;
    onehot = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one I2C master engine among NUM_REQ requesters
module i2c_req_arbiter import i2c_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*I2C_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*I2C_DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]             req_wr,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_done,
  output logic [NUM_REQ-1:0]             rsp_err,
  output logic [I2C_ADDR_W-1:0]          m_addr,
  output logic [I2C_DATA_W-1:0]          m_data,
  output logic                           m_wr_bit,
  output logic                           m_run,
  input  logic                           m_busy,
  input  logic                           m_nack,
  output logic [IW-1:0]                  gnt_id,
  output logic                           arb_busy
);
  arb_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr, pick_idx;
  logic [NUM_REQ-1:0] pick_oh, own_oh;
  logic pick_any, nack_f, err, err_nx, tmo;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid(req_valid), .ptr(ptr), .any(pick_any), .idx(pick_idx), .onehot(pick_oh)
  );

  assign tmo = cnt == CW'(TIMEOUT);

  // counter restarts on every state change and saturates at TIMEOUT
  always_ff @(posedge sys_clk)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= state_nx != state ? '0 : cnt + CW'(!tmo);
    end

  always_ff @(posedge sys_clk)
    if (!rst) begin
      ptr <= '0;
      gnt_id <= '0;
      own_oh <= '0;
      m_addr <= '0;
      m_data <= '0;
      m_wr_bit <= 1'b0;
      nack_f <= 1'b0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && pick_any) begin
        ptr <= pick_idx == IW'(NUM_REQ - 1) ? '0 : pick_idx + IW'(1);
        gnt_id <= pick_idx;
        own_oh <= pick_oh;
        m_addr <= req_addr[pick_idx*I2C_ADDR_W +: I2C_ADDR_W];
        m_data <= req_data[pick_idx*I2C_DATA_W +: I2C_DATA_W];
        m_wr_bit <= req_wr[pick_idx];
      end
      nack_f <= state == WAIT && (nack_f || (m_nack && m_busy));
      err <= err_nx;
    end

  always_comb begin
    state_nx = state;
    err_nx = err;
    case (state)
      IDLE: if (pick_any) state_nx = LAUNCH;
      LAUNCH:
        if (m_busy) state_nx = WAIT;
        else if (tmo) begin
          state_nx = DONE;
          err_nx = 1'b1;
        end
      WAIT:
        if (!m_busy) begin
          state_nx = DONE;
          err_nx = nack_f;
        end else if (tmo) begin
          state_nx = DONE;
          err_nx = 1'b1;
        end
      default: state_nx = IDLE;
    endcase
  end

  // first LAUNCH cycle is the only one with cnt at zero, giving the accept pulse
  always_comb begin
    m_run = state == LAUNCH;
    arb_busy = state != IDLE;
    req_ready = state == LAUNCH && cnt == '0 ? own_oh : '0;
    rsp_done = state == DONE ? own_oh : '0;
    rsp_err = state == DONE && err ? own_oh : '0;
  end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: table vectors, hand sequences and random traffic checked
// against a transaction-level model of grant order, fields and completion status
module tb_i2c_req_arbiter;
  localparam int N = 4;
  localparam int TO = 15;

  logic sys_clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req_valid = '0, req_wr = '0;
  logic [N*8-1:0] req_addr = '0, req_data = '0;
  logic [N-1:0] req_ready, rsp_done, rsp_err;
  logic [7:0] m_addr, m_data;
  logic m_wr_bit, m_run, arb_busy;
  logic m_busy = 1'b0, m_nack = 1'b0;
  logic [1:0] gnt_id;
  int vectors = 0, miscompares = 0;

  // master behaviour knobs and state
  int mode = 0, dly = 1, len = 2, nack_at = 0, phase = 0, mcnt = 0;
  bit nack_sent = 0;
  // reference model state
  int ptr = 0, owner = -1;
  bit idle_exp = 0, post_done = 0;
  logic [N-1:0] pv, pwr;
  logic [N*8-1:0] paddr, pdata;
  logic prst, pbusy;

  typedef struct {
    logic [N-1:0] v;
    int d;
    int l;
    int na;
    int g;
    logic e;
  } vec_t;
  vec_t tbl[14];

  always #5 sys_clk = ~sys_clk;

  i2c_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_wr(req_wr), .req_ready(req_ready), .rsp_done(rsp_done),
    .rsp_err(rsp_err), .m_addr(m_addr), .m_data(m_data), .m_wr_bit(m_wr_bit),
    .m_run(m_run), .m_busy(m_busy), .m_nack(m_nack), .gnt_id(gnt_id), .arb_busy(arb_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] r;
    r = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  task automatic step();
    int g;
    bit granted;
    pv = req_valid; pwr = req_wr; paddr = req_addr; pdata = req_data; prst = rst; pbusy = m_busy;
    @(posedge sys_clk);
    #1;
    granted = 0;
    if (!prst) begin
      chk("reset_outputs", {req_ready, rsp_done, rsp_err, m_addr, m_data, m_wr_bit, m_run, gnt_id, arb_busy}, '0);
      ptr = 0; owner = -1; idle_exp = 1; post_done = 0;
    end else begin
      if (idle_exp) begin
        g = pick(pv, ptr);
        if (g >= 0) begin
          chk("grant_ready", req_ready, oh(g));
          chk("grant_fields", {m_addr, m_data, m_wr_bit, m_run, arb_busy, gnt_id},
              {paddr[g*8 +: 8], pdata[g*8 +: 8], pwr[g], 1'b1, 1'b1, 2'(g)});
          owner = g; ptr = (g + 1) % N; idle_exp = 0; nack_sent = 0; granted = 1;
        end else chk("idle_no_ready", {req_ready, arb_busy, m_run}, '0);
      end else chk("no_stray_ready", req_ready, '0);
      if (post_done) begin
        chk("post_done_idle", {arb_busy, rsp_done}, '0);
        post_done = 0; idle_exp = 1;
      end else if (rsp_done != '0) begin
        if (owner < 0) chk("done_without_owner", rsp_done, '0);
        else begin
          chk("rsp_done", rsp_done, oh(owner));
          chk("rsp_err", rsp_err, (nack_sent || mode != 0) ? oh(owner) : '0);
          owner = -1; post_done = 1;
        end
      end else begin
        if (rsp_err != '0) chk("err_without_done", rsp_err, '0);
        if (owner >= 0 && !granted) chk("own_hold", {arb_busy, gnt_id, m_run & pbusy}, {1'b1, 2'(owner), 1'b0});
      end
    end
    m_nack = 1'b0;
    if (mode == 1) m_busy = 1'b0;
    else if (mode == 2) begin
      if (m_run) m_busy = 1'b1;
    end else if (phase == 0) begin
      if (m_run) begin
        mcnt++;
        if (mcnt >= dly) begin m_busy = 1'b1; phase = 1; mcnt = 0; end
      end else mcnt = 0;
    end else begin
      mcnt++;
      if (mcnt == len) begin m_busy = 1'b0; phase = 0; mcnt = 0; end
      else if (mcnt == nack_at) begin m_nack = 1'b1; nack_sent = 1; end
    end
  endtask

  task automatic wait_ready(input int lim);
    for (int i = 0; i < lim; i++) begin
      step();
      if (req_ready != '0) break;
    end
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim; i++) begin
      step();
      if (rsp_done != '0) break;
    end
  endtask

  initial begin
    int runc;
    tbl[0]  = '{4'b1111, 2, 4, 0, 0, 1'b0};
    tbl[1]  = '{4'b1111, 1, 3, 0, 1, 1'b0};
    tbl[2]  = '{4'b1111, 3, 5, 0, 2, 1'b0};
    tbl[3]  = '{4'b1111, 2, 2, 0, 3, 1'b0};
    tbl[4]  = '{4'b1111, 4, 6, 0, 0, 1'b0};
    tbl[5]  = '{4'b1111, 1, 4, 0, 1, 1'b0};
    tbl[6]  = '{4'b1111, 3, 6, 2, 2, 1'b1};
    tbl[7]  = '{4'b1111, 1, 3, 0, 3, 1'b0};
    tbl[8]  = '{4'b1001, 2, 3, 0, 0, 1'b0};
    tbl[9]  = '{4'b1001, 2, 3, 0, 3, 1'b0};
    tbl[10] = '{4'b0001, 5, 10, 0, 0, 1'b0};
    tbl[11] = '{4'b0110, 1, 2, 0, 1, 1'b0};
    tbl[12] = '{4'b0100, 2, 5, 4, 2, 1'b1};
    tbl[13] = '{4'b0001, 1, 2, 0, 0, 1'b0};
    for (int i = 0; i < N; i++) begin
      req_addr[i*8 +: 8] = 8'h50 + 8'(i);
      req_data[i*8 +: 8] = 8'hA5 + 8'(i);
      req_wr[i] = 1'(i);
    end
    req_wr[0] = 1'b0;
    req_valid = 4'b1111;
    step();
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    for (int r = 0; r < 14; r++) begin
      req_valid = tbl[r].v; dly = tbl[r].d; len = tbl[r].l; nack_at = tbl[r].na;
      wait_ready(64);
      chk("tbl_ready", req_ready, oh(tbl[r].g));
      wait_done(64);
      chk("tbl_rsp", {rsp_done, rsp_err}, {oh(tbl[r].g), tbl[r].e ? oh(tbl[r].g) : 4'b0});
    end
    req_valid = '0;
    step(); step();
    // launch timeout: master never goes busy
    mode = 1; runc = 0; req_valid = 4'b0010;
    for (int i = 0; i < 60 && rsp_done == '0; i++) begin
      step();
      if (req_ready != '0) req_valid = '0;
      if (m_run) runc++;
    end
    chk("launch_to_len", 64'(runc == TO || runc == TO + 1), 64'(1));
    chk("launch_to_rsp", {rsp_done, rsp_err}, {4'b0010, 4'b0010});
    step(); step();
    chk("launch_to_idle", arb_busy, 1'b0);
    // wait timeout: busy stuck high
    mode = 2; req_valid = 4'b0100;
    for (int i = 0; i < 60 && rsp_done == '0; i++) begin
      step();
      if (req_ready != '0) req_valid = '0;
    end
    chk("wait_to_rsp", {rsp_done, rsp_err}, {4'b0100, 4'b0100});
    mode = 0; m_busy = 1'b0; phase = 0; mcnt = 0;
    step(); step();
    chk("wait_to_idle", arb_busy, 1'b0);
    // reset while in WAIT
    dly = 2; len = 12; nack_at = 0; req_valid = 4'b0010;
    for (int i = 0; i < 30 && !(arb_busy && !m_run && m_busy); i++) begin
      step();
      if (req_ready != '0) req_valid = '0;
    end
    chk("reached_wait", {arb_busy, m_run, m_busy}, 3'b101);
    rst = 1'b0;
    step();
    rst = 1'b1; m_busy = 1'b0; phase = 0; mcnt = 0;
    for (int i = 0; i < 5; i++) step();
    req_valid = 4'b0110; dly = 1; len = 3;
    wait_ready(20);
    chk("reset_ptr_grant", req_ready, 4'b0010);
    req_valid = 4'b0100;
    wait_done(40);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_addr[i*8 +: 8] = 8'($urandom);
          req_data[i*8 +: 8] = 8'($urandom);
          req_wr[i] = 1'($urandom);
        end
      step();
      if (req_ready != '0) begin
        req_valid = req_valid & ~req_ready;
        dly = $urandom_range(1, 4);
        len = $urandom_range(2, 8);
        nack_at = $urandom_range(0, 3) == 0 ? $urandom_range(1, len - 1) : 0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
